ex: RTL and testbench
=====================

// Module: ex
// PURPOSE
// - Execute stage. Consumes the registered ID/EX bundle and computes ALU, shift, compare and HI/LO results.
// - Runs signed/unsigned divide on an iterative 32-step divider; stallreq_o freezes IF..ID/EX while it runs.
// - Results go combinationally to the EX/MEM register.
// PARAMETERS
// - DATA_W  32  operand/result width; the divider runs exactly DATA_W iteration cycles
// PORTS
// - clk        in   1         rising-edge clock
// - rst        in   1         asynchronous reset, active-low (rst==0 resets)
// - aluop_i    in   `AluOpBus    operation code from ID/EX
// - alusel_i   in   `AluSelBus   result class (logic/shift/arith/move/nop)
// - reg1_i     in   DATA_W    operand 1
// - reg2_i     in   DATA_W    operand 2 / shift source
// - wd_i       in   `RegAddrBus  destination register
// - wreg_i     in   1         destination write enable
// - hi_i       in   DATA_W    current HI (already forwarded from MEM/WB)
// - lo_i       in   DATA_W    current LO (already forwarded from MEM/WB)
// - annul_i    in   1         flush: abort any in-flight divide
// - wd_o       out  `RegAddrBus  = wd_i
// - wreg_o     out  1         write enable (forced 0 on ADD/SUB overflow)
// - wdata_o    out  DATA_W    GPR write data
// - whilo_o    out  1         HI/LO write enable
// - hi_o       out  DATA_W    HI write data
// - lo_o       out  DATA_W    LO write data
// - stallreq_o out  1         pipeline stall request
// BEHAVIOUR
// - Reset (rst==0, async): divider FSM=IDLE, internal regs 0; all outputs 0 (wd_o=`NOPRegAddr).
// - Non-divide ops: zero latency, purely combinational from the *_i inputs.
// - Logic: AND/OR/XOR/NOR/LUI-style OR.
// - Shifts: SLL/SRL/SRA using reg1_i[4:0] as the shift amount.
// - Arithmetic: ADDU/SUBU wrap mod 2^32. ADD/SUB: signed overflow -> wreg_o=0 and wdata_o unchanged.
// - Compares: SLT signed, SLTU unsigned; result is 0 or 1.
// - Moves: MFHI/MFLO -> wdata_o. MTHI/MTLO -> whilo_o=1, other half passes through unchanged.
// - Divider FSM states: IDLE, DIVZERO, BUSY, DONE.
// - IDLE: on DIV/DIVU with annul_i=0, go to DIVZERO if reg2_i==0, else BUSY. Latch |operands| and signs; count=0.
// - DIVZERO: 1 cycle, result {HI,LO}=0, then DONE.
// - BUSY: one restoring shift-subtract step per cycle. After DATA_W steps (count==DATA_W-1), go to DONE.
// - DONE: drive whilo_o=1, lo_o=quotient, hi_o=remainder; go to IDLE.
// - Sign correction (DIV): quotient negated if the operand signs differ; remainder takes the dividend's sign.
// - Divide edge case: DIV 0x80000000 / -1 gives LO=0x80000000, HI=0.
// - stallreq_o=1 combinationally in IDLE (when a divide is present), DIVZERO and BUSY; 0 in DONE.
// - Latency: nonzero divisor -> result in cycle DATA_W+1 after issue; zero divisor -> cycle 2.
// - Operands are held stable by the upstream stall. The FSM uses latched copies, never live inputs, in BUSY.
// - annul_i=1 in any state: go to IDLE next cycle, stallreq_o=0 that cycle, whilo_o=0, no result.
// - Back-to-back divides: DONE->IDLE, the next divide issues the following cycle (1 bubble).
// - Async reset mid-divide: FSM goes to IDLE immediately; the partial result is discarded.
// - Unknown aluop: wdata_o=0, whilo_o=0, wreg_o passed through.
// CONFIGURATION
// - EX_MUL_EN defined:
//   - MULT/MULTU: single-cycle 32x32->64 product, {hi_o,lo_o}=product, whilo_o=1, no stall.
//   - MUL: GPR gets product[31:0].
// - EX_MUL_EN undefined: MULT/MULTU/MUL decode as NOP (wreg_o=0, whilo_o=0) and no multiplier is built.
// STRUCTURE
// - inc/defines.v (shared): new EXE_DIV_OP/EXE_DIVU_OP/EXE_MULT*_OP codes, EXE_RES_MOVE/EXE_RES_MUL classes,
//   DivFree/DivByZero/DivOn/DivEnd state encodings, DivResultReady/NotReady, StallRequest.
// - Sub-module div_iter: FSM, counter, dividend/remainder shift register, sign fix-up.
//   Interface: start, signed, opdata1, opdata2, annul -> result[63:0], ready.
// - ex keeps the combinational ALU/mux and the stall logic.
// TESTING
// - 1. ADD 0x7FFFFFFF+1 -> wreg_o=0. ADDU same -> wdata_o=0x80000000, wreg_o=1.
// - 2. SRA reg2=0xF0000000 by 4 -> 0xFF000000. SLT -1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0.
// - 3. DIV -7/2 -> stallreq_o high 33 cycles, then 1 cycle with whilo_o=1, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
// - 4. DIVU 5/0 -> stall 2 cycles, then whilo_o=1, HI=LO=0. DIVU 100/7 -> LO=14, HI=2.
// - 5. annul_i pulse at BUSY step 10 -> stallreq_o=0 next cycle, whilo_o never asserted, FSM in IDLE.
// - 6. rst low mid-BUSY -> all outputs 0 that cycle; after release, DIVU 9/3 -> LO=3, HI=0.
//   With EX_MUL_EN: MULT -2*3 -> {HI,LO}=0xFFFFFFFF_FFFFFFFA.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: operation codes, result classes,
// bus widths and the divider state type.
package ex_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  // Result classes
  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_MUL   = 3'b101;

  // Operation codes
  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [ALU_OP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [ALU_OP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [ALU_OP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [ALU_OP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [ALU_OP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [ALU_OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [ALU_OP_W-1:0] EXE_MUL_OP   = 8'b1010_1001;

  // Divider states
  typedef enum logic [1:0] {
    DIV_FREE     = 2'b00,
    DIV_BY_ZERO  = 2'b01,
    DIV_ON       = 2'b10,
    DIV_END      = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
//
// state       | meaning
// ------------+-------------------------------------------------------
// DIV_FREE    | idle, waiting for start; latches |operands| and signs
// DIV_BY_ZERO | divisor was zero, result forced to 0 for one cycle
// DIV_ON      | shift-subtract steps, count 0..DATA_W-1
// DIV_END     | result valid (ready_o=1) for exactly one cycle
//
// annul_i returns the FSM to DIV_FREE from any state; rst is async active-low.
module ex_div_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e          state_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   divisor_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;

  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   quo_d;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                neg1;
  logic                neg2;

  // One restoring step plus the sign fix-up applied on the final step
  always_comb begin
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    diff      = rem_shift - {1'b0, divisor_q};
    if (!diff[DATA_W]) begin
      rem_d = diff[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_d = rem_shift[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b0};
    end
    quo_fix = neg_quo_q ? -quo_d : quo_d;
    rem_fix = neg_rem_q ? -rem_d : rem_d;
    neg1    = signed_i & opdata1_i[DATA_W-1];
    neg2    = signed_i & opdata2_i[DATA_W-1];
  end

  // Divider FSM with registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (annul_i) begin
      state_q <= DIV_FREE;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (start_i) begin
            neg_quo_q <= neg1 ^ neg2;
            neg_rem_q <= neg1;
            quo_q     <= neg1 ? -opdata1_i : opdata1_i;
            divisor_q <= neg2 ? -opdata2_i : opdata2_i;
            rem_q     <= '0;
            count_q   <= '0;
            state_q   <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          result_q <= '0;
          state_q  <= DIV_END;
        end
        DIV_ON: begin
          quo_q   <= quo_d;
          rem_q   <= rem_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(DATA_W-1)) begin
            result_q <= {rem_fix, quo_fix};
            state_q  <= DIV_END;
          end
        end
        default: state_q <= DIV_FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == DIV_END);
  assign busy_o   = (state_q == DIV_BY_ZERO) || (state_q == DIV_ON);

endmodule

// File: rtl/ex.sv
// Execute stage: combinational ALU/shift/compare/move datapath, HI/LO write
// generation, and stall control around the iterative divider.
// Optional feature macro: EX_MUL_EN builds the single-cycle multiplier
// (MULT/MULTU/MUL); without it those opcodes behave as NOPs.
module ex
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [ALU_SEL_W-1:0]  alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic                  annul_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     sh_amt;
  logic [DATA_W-1:0]   sum_add;
  logic [DATA_W-1:0]   sum_sub;
  logic                ov_add;
  logic                ov_sub;
  logic                lt_s;
  logic                lt_u;
  logic                is_div;
  logic [2*DATA_W-1:0] div_result;
  logic                div_ready;
  logic                div_busy;
  logic                div_idle;

  logic [DATA_W-1:0]   wdata_w;
  logic                wreg_w;
  logic                whilo_w;
  logic [DATA_W-1:0]   hi_w;
  logic [DATA_W-1:0]   lo_w;
  logic                stall_w;

  assign sh_amt  = reg1_i[SH_W-1:0];
  assign sum_add = reg1_i + reg2_i;
  assign sum_sub = reg1_i - reg2_i;
  assign ov_add  = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) && (sum_add[DATA_W-1] != reg1_i[DATA_W-1]);
  assign ov_sub  = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) && (sum_sub[DATA_W-1] != reg1_i[DATA_W-1]);
  assign lt_s    = $signed(reg1_i) < $signed(reg2_i);
  assign lt_u    = reg1_i < reg2_i;
  assign is_div  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  ex_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (is_div && !annul_i),
    .signed_i  (aluop_i == EXE_DIV_OP),
    .opdata1_i (reg1_i),
    .opdata2_i (reg2_i),
    .annul_i   (annul_i),
    .result_o  (div_result),
    .ready_o   (div_ready),
    .busy_o    (div_busy)
  );

  assign div_idle = !div_busy && !div_ready;

`ifdef EX_MUL_EN
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] mul_b;
  logic [2*DATA_W-1:0] product;
  logic                mul_signed;

  // Extending to full width first gives the correct low 2*DATA_W bits for both signednesses
  assign mul_signed = (aluop_i != EXE_MULTU_OP);
  assign mul_a      = {{DATA_W{mul_signed & reg1_i[DATA_W-1]}}, reg1_i};
  assign mul_b      = {{DATA_W{mul_signed & reg2_i[DATA_W-1]}}, reg2_i};
  assign product    = mul_a * mul_b;
`endif

  // Result selection, HI/LO write generation and stall request
  always_comb begin
    wdata_w = '0;
    wreg_w  = wreg_i;
    whilo_w = 1'b0;
    hi_w    = '0;
    lo_w    = '0;

    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_AND_OP: wdata_w = reg1_i & reg2_i;
          EXE_OR_OP:  wdata_w = reg1_i | reg2_i;
          EXE_XOR_OP: wdata_w = reg1_i ^ reg2_i;
          EXE_NOR_OP: wdata_w = ~(reg1_i | reg2_i);
          default:    wdata_w = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: wdata_w = reg2_i << sh_amt;
          EXE_SRL_OP: wdata_w = reg2_i >> sh_amt;
          EXE_SRA_OP: wdata_w = $unsigned($signed(reg2_i) >>> sh_amt);
          default:    wdata_w = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (aluop_i)
          EXE_ADD_OP: begin
            wdata_w = sum_add;
            wreg_w  = wreg_i && !ov_add;
          end
          EXE_ADDU_OP: wdata_w = sum_add;
          EXE_SUB_OP: begin
            wdata_w = sum_sub;
            wreg_w  = wreg_i && !ov_sub;
          end
          EXE_SUBU_OP: wdata_w = sum_sub;
          EXE_SLT_OP:  wdata_w = {{(DATA_W-1){1'b0}}, lt_s};
          EXE_SLTU_OP: wdata_w = {{(DATA_W-1){1'b0}}, lt_u};
          default:     wdata_w = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: wdata_w = hi_i;
          EXE_MFLO_OP: wdata_w = lo_i;
          default:     wdata_w = '0;
        endcase
      end
`ifdef EX_MUL_EN
      EXE_RES_MUL: begin
        if (aluop_i == EXE_MUL_OP) wdata_w = product[DATA_W-1:0];
      end
`endif
      default: wdata_w = '0;
    endcase

    case (aluop_i)
      EXE_MTHI_OP: begin
        whilo_w = 1'b1;
        hi_w    = reg1_i;
        lo_w    = lo_i;
      end
      EXE_MTLO_OP: begin
        whilo_w = 1'b1;
        hi_w    = hi_i;
        lo_w    = reg1_i;
      end
`ifdef EX_MUL_EN
      EXE_MULT_OP, EXE_MULTU_OP: begin
        whilo_w      = 1'b1;
        {hi_w, lo_w} = product;
      end
`else
      EXE_MULT_OP, EXE_MULTU_OP, EXE_MUL_OP: begin
        wreg_w  = 1'b0;
        wdata_w = '0;
      end
`endif
      default: ;
    endcase

    // Divider result wins while its single DONE cycle is showing
    if (div_ready && !annul_i) begin
      whilo_w      = 1'b1;
      {hi_w, lo_w} = div_result;
    end

    stall_w = !annul_i && (div_busy || (div_idle && is_div));

    if (!rst) begin
      wd_o       = NOP_REG_ADDR;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
    end else begin
      wd_o       = wd_i;
      wreg_o     = wreg_w;
      wdata_o    = wdata_w;
      whilo_o    = whilo_w;
      hi_o       = hi_w;
      lo_o       = lo_w;
      stallreq_o = stall_w;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: a vector table for the single-cycle
// operations plus hand-written divide, annul and reset sequences.
module tb_ex;
  import ex_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [ALU_OP_W-1:0]   aluop_i;
  logic [ALU_SEL_W-1:0]  alusel_i;
  logic [31:0]           reg1_i;
  logic [31:0]           reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic [31:0]           hi_i;
  logic [31:0]           lo_i;
  logic                  annul_i;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [31:0]           wdata_o;
  logic                  whilo_o;
  logic [31:0]           hi_o;
  logic [31:0]           lo_o;
  logic                  stallreq_o;

  int checks;
  int failures;

  ex #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .annul_i    (annul_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wreg_in;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic        wreg;
    logic        whilo;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t  vecs[$];
  string names[$];

  function automatic void add(input string nm, input logic [7:0] op, input logic [2:0] sel,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] hi, input logic [31:0] lo, input logic wi,
                              input logic cw, input logic [31:0] wd, input logic wr,
                              input logic wh, input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2; v.hi = hi; v.lo = lo;
    v.wreg_in = wi; v.chk_wdata = cw; v.wdata = wd; v.wreg = wr; v.whilo = wh;
    v.ehi = eh; v.elo = el;
    vecs.push_back(v);
    names.push_back(nm);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic wi);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wreg_i   = wi;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " wd"},    64'(wd_o), 64'd0);
    chk({nm, " wreg"},  64'(wreg_o), 64'd0);
    chk({nm, " wdata"}, 64'(wdata_o), 64'd0);
    chk({nm, " whilo"}, 64'(whilo_o), 64'd0);
    chk({nm, " hilo"},  {hi_o, lo_o}, 64'd0);
    chk({nm, " stall"}, 64'(stallreq_o), 64'd0);
  endtask

  // Issue a divide at the next edge, count stall cycles, then check the DONE cycle
  task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] ehi, input logic [31:0] elo);
    int   n;
    logic early;
    @(posedge clk); #1;
    set_in(op, EXE_RES_NOP, a, b, 1'b0);
    n = 0;
    early = 1'b0;
    forever begin
      @(negedge clk);
      if (stallreq_o) begin
        n++;
        if (whilo_o) early = 1'b1;
        if (n > 200) break;
      end else begin
        break;
      end
    end
    chk({nm, " stall cycles"}, 64'(n), 64'(exp_stall));
    chk({nm, " whilo during stall"}, 64'(early), 64'd0);
    chk({nm, " whilo"}, 64'(whilo_o), 64'd1);
    chk({nm, " lo"}, 64'(lo_o), 64'(elo));
    chk({nm, " hi"}, 64'(hi_o), 64'(ehi));
  endtask

  task automatic idle_cycle(input string nm);
    @(posedge clk); #1;
    set_in(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk({nm, " idle stall"}, 64'(stallreq_o), 64'd0);
    chk({nm, " idle whilo"}, 64'(whilo_o), 64'd0);
  endtask

  initial begin
    logic seen;
    checks   = 0;
    failures = 0;

    add("add_ovf",  EXE_ADD_OP,  EXE_RES_ARITH, 32'h7FFFFFFF, 32'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add("addu",     EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFFFFFF, 32'h1, 0, 0, 1, 1, 32'h80000000, 1, 0, 0, 0);
    add("add_ok",   EXE_ADD_OP,  EXE_RES_ARITH, 32'd5, 32'hFFFFFFFD, 0, 0, 1, 1, 32'd2, 1, 0, 0, 0);
    add("sub_ovf",  EXE_SUB_OP,  EXE_RES_ARITH, 32'h80000000, 32'h1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add("subu",     EXE_SUBU_OP, EXE_RES_ARITH, 32'd0, 32'd1, 0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
    add("sra",      EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4, 32'hF0000000, 0, 0, 1, 1, 32'hFF000000, 1, 0, 0, 0);
    add("srl",      EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4, 32'hF0000000, 0, 0, 1, 1, 32'h0F000000, 1, 0, 0, 0);
    add("sll",      EXE_SLL_OP,  EXE_RES_SHIFT, 32'd31, 32'd3, 0, 0, 1, 1, 32'h80000000, 1, 0, 0, 0);
    add("slt",      EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 1, 32'd1, 1, 0, 0, 0);
    add("sltu_ge",  EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 1, 32'd0, 1, 0, 0, 0);
    add("sltu_lt",  EXE_SLTU_OP, EXE_RES_ARITH, 32'd1, 32'hFFFFFFFF, 0, 0, 1, 1, 32'd1, 1, 0, 0, 0);
    add("and",      EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 1, 1, 32'h0F000F00, 1, 0, 0, 0);
    add("or",       EXE_OR_OP,   EXE_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 1, 1, 32'hFFF0FFF0, 1, 0, 0, 0);
    add("xor",      EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 1, 1, 32'hF0F0F0F0, 1, 0, 0, 0);
    add("nor",      EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0, 32'h0, 0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
    add("mfhi",     EXE_MFHI_OP, EXE_RES_MOVE, 0, 0, 32'h12345678, 32'h9ABCDEF0, 1, 1, 32'h12345678, 1, 0, 0, 0);
    add("mflo",     EXE_MFLO_OP, EXE_RES_MOVE, 0, 0, 32'h12345678, 32'h9ABCDEF0, 1, 1, 32'h9ABCDEF0, 1, 0, 0, 0);
    add("mthi",     EXE_MTHI_OP, EXE_RES_NOP, 32'hAAAA5555, 0, 32'd1, 32'd2, 0, 1, 0, 0, 1, 32'hAAAA5555, 32'd2);
    add("mtlo",     EXE_MTLO_OP, EXE_RES_NOP, 32'h0BADF00D, 0, 32'd3, 32'd4, 0, 1, 0, 0, 1, 32'd3, 32'h0BADF00D);
    add("unknown",  8'hFF,       EXE_RES_LOGIC, 32'h1234, 32'h5678, 0, 0, 1, 1, 32'd0, 1, 0, 0, 0);
`ifdef EX_MUL_EN
    add("mult",     EXE_MULT_OP,  EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 0, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    add("multu",    EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 1, 0, 0, 1, 32'h1, 32'hFFFFFFFE);
    add("mul",      EXE_MUL_OP,   EXE_RES_MUL, 32'hFFFFFFFE, 32'd3, 0, 0, 1, 1, 32'hFFFFFFFA, 1, 0, 0, 0);
`else
    add("mult_nop", EXE_MULT_OP,  EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add("mul_nop",  EXE_MUL_OP,   EXE_RES_MUL, 32'hFFFFFFFE, 32'd3, 0, 0, 1, 1, 0, 0, 0, 0, 0);
`endif

    // Reset state with a busy-looking input bundle
    rst     = 1'b0;
    annul_i = 1'b0;
    wd_i    = 5'd7;
    hi_i    = 32'h11111111;
    lo_i    = 32'h22222222;
    set_in(EXE_ADDU_OP, EXE_RES_ARITH, 32'd1, 32'd2, 1'b1);
    #3;
    chk_all_zero("reset");
    #9 rst = 1'b1;

    // Single-cycle vector table
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      set_in(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].wreg_in);
      hi_i = vecs[i].hi;
      lo_i = vecs[i].lo;
      @(negedge clk);
      chk({names[i], " wd"}, 64'(wd_o), 64'd7);
      chk({names[i], " wreg"}, 64'(wreg_o), 64'(vecs[i].wreg));
      chk({names[i], " whilo"}, 64'(whilo_o), 64'(vecs[i].whilo));
      chk({names[i], " stall"}, 64'(stallreq_o), 64'd0);
      if (vecs[i].chk_wdata) chk({names[i], " wdata"}, 64'(wdata_o), 64'(vecs[i].wdata));
      if (vecs[i].whilo) chk({names[i], " hilo"}, {hi_o, lo_o}, {vecs[i].ehi, vecs[i].elo});
    end

    // Divides
    run_div("div -7/2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    idle_cycle("div -7/2");
    run_div("divu 5/0", EXE_DIVU_OP, 32'd5, 32'd0, 2, 32'd0, 32'd0);
    idle_cycle("divu 5/0");
    run_div("div min/-1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);
    // back-to-back: next divide issued directly after the DONE cycle
    run_div("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_div("div 7/-2", EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
    idle_cycle("div 7/-2");

    // Annul at BUSY step 10 (cycle 11 after issue)
    @(posedge clk); #1;
    set_in(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 1'b0);
    repeat (11) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    chk("annul stall same cycle", 64'(stallreq_o), 64'd0);
    chk("annul whilo same cycle", 64'(whilo_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    set_in(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (whilo_o || stallreq_o) seen = 1'b1;
    end
    chk("annul no result/stall after", 64'(seen), 64'd0);
    run_div("divu 9/3 after annul", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd0, 32'd3);
    idle_cycle("after annul");

    // Async reset mid-BUSY
    @(posedge clk); #1;
    set_in(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("mid-busy reset");
    @(posedge clk); #1;
    set_in(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("post reset stall", 64'(stallreq_o), 64'd0);
    chk("post reset whilo", 64'(whilo_o), 64'd0);
    run_div("divu 9/3 after reset", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd0, 32'd3);
    idle_cycle("after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
